// File: rtl/datapath_gen.sv
// Register-file datapath: one-hot shared bus, HI/LO/Z/PC/IR/Y/MAR/MDR registers,
// and a two-state memory handshake FSM with a wait-cycle timeout.
module datapath_gen #(
    parameter int WIDTH       = 32,
    parameter int NREGS       = 16,
    parameter int PC_STEP     = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     in_clr,
    input  logic [$clog2(NREGS)-1:0] in_regfile_location,
    input  logic [8:0]               in_bus_select,
    input  logic [8:0]               in_write,
    input  logic                     in_inc_pc,
    input  logic [WIDTH-1:0]         in_inport_data,
    input  logic [WIDTH-1:0]         in_c_data,
    input  logic [2*WIDTH-1:0]       in_alu_result,
    output logic [WIDTH-1:0]         out_alu_a,
    output logic [WIDTH-1:0]         out_alu_b,
    input  logic                     in_mem_start,
    input  logic                     in_mem_we,
    output logic                     out_mem_req,
    output logic                     out_mem_we,
    output logic [WIDTH-1:0]         out_mem_addr,
    output logic [WIDTH-1:0]         out_mem_wdata,
    input  logic [WIDTH-1:0]         in_mem_rdata,
    input  logic                     in_mem_ack,
    output logic                     out_mem_busy,
    output logic                     out_mem_timeout,
    output logic                     out_bus_error,
    output logic [WIDTH-1:0]         out_bus,
    output logic [WIDTH-1:0]         out_ir
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    // Write-enable bit positions
    localparam int WR_REG = 0;
    localparam int WR_HI  = 1;
    localparam int WR_LO  = 2;
    localparam int WR_Z   = 3;
    localparam int WR_PC  = 4;
    localparam int WR_MDR = 5;
    localparam int WR_IR  = 6;
    localparam int WR_Y   = 7;
    localparam int WR_MAR = 8;

    typedef enum logic {ST_IDLE, ST_WAIT} mem_state_t;

    logic [WIDTH-1:0]   regs [NREGS];
    logic [WIDTH-1:0]   hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q;
    logic [2*WIDTH-1:0] z_q;
    logic               bus_err_q, timeout_q, mem_we_q;
    logic [CW-1:0]      cnt_q, cnt_next, cnt_inc;
    mem_state_t         state_q, state_next;

    logic [WIDTH-1:0]   bus;
    logic               multi_sel;
    logic [8:0]         we_eff;
    logic               busy, timeout_set, mem_capture, start_accept;

    // A select word with more than one bit set clears to nonzero when x & (x-1) is taken.
    assign multi_sel = (in_bus_select & (in_bus_select - 9'd1)) != 9'd0;
    assign we_eff    = multi_sel ? 9'd0 : in_write;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        bus = '0;
        case (in_bus_select)
            9'b0_0000_0001: bus = regs[in_regfile_location];
            9'b0_0000_0010: bus = hi_q;
            9'b0_0000_0100: bus = lo_q;
            9'b0_0000_1000: bus = z_q[2*WIDTH-1:WIDTH];
            9'b0_0001_0000: bus = z_q[WIDTH-1:0];
            9'b0_0010_0000: bus = pc_q;
            9'b0_0100_0000: bus = mdr_q;
            9'b0_1000_0000: bus = in_inport_data;
            9'b1_0000_0000: bus = in_c_data;
            default:        bus = '0;
        endcase
    end

    assign busy    = (state_q == ST_WAIT);
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_next   = state_q;
        cnt_next     = cnt_q;
        timeout_set  = 1'b0;
        mem_capture  = 1'b0;
        start_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_mem_start) begin
                    start_accept = 1'b1;
                    state_next   = ST_WAIT;
                    cnt_next     = '0;
                end
            end
            ST_WAIT: begin
                if (in_mem_ack) begin
                    state_next  = ST_IDLE;
                    mem_capture = !mem_we_q;
                end else if (cnt_inc == CW'(MEM_TIMEOUT)) begin
                    state_next  = ST_IDLE;
                    timeout_set = 1'b1;
                    cnt_next    = cnt_inc;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (in_clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mem_we_q  <= 1'b0;
            timeout_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            if (start_accept) mem_we_q  <= in_mem_we;
            if (timeout_set)  timeout_q <= 1'b1;
            if (multi_sel)    bus_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_clr) begin
            // NOTE: the register file is cleared on reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            z_q   <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            if (we_eff[WR_REG]) regs[in_regfile_location] <= bus;
            if (we_eff[WR_HI])  hi_q <= bus;
            if (we_eff[WR_LO])  lo_q <= bus;
            if (we_eff[WR_Z])   z_q  <= in_alu_result;
            if (we_eff[WR_IR])  ir_q <= bus;
            if (we_eff[WR_Y])   y_q  <= bus;

            if (in_inc_pc)          pc_q <= pc_q + WIDTH'(PC_STEP);
            else if (we_eff[WR_PC]) pc_q <= bus;

            if (we_eff[WR_MAR] && !busy) mar_q <= bus;

            // Read data wins over the bus; MDR is frozen while it is being written out.
            if (mem_capture)                             mdr_q <= in_mem_rdata;
            else if (we_eff[WR_MDR] && !(busy && mem_we_q)) mdr_q <= bus;
        end
    end

    assign out_bus         = bus;
    assign out_alu_a       = y_q;
    assign out_alu_b       = bus;
    assign out_ir          = ir_q;
    assign out_mem_addr    = mar_q;
    assign out_mem_wdata   = mdr_q;
    assign out_mem_req     = busy;
    assign out_mem_busy    = busy;
    assign out_mem_we      = mem_we_q;
    assign out_mem_timeout = timeout_q;
    assign out_bus_error   = bus_err_q;

endmodule

// File: tb/tb_datapath_gen.sv
// Directed bench for datapath_gen: expected values queued at stimulus time,
// popped and asserted when the corresponding DUT output is sampled.
module tb_datapath_gen;

    localparam int W  = 32;
    localparam int NR = 16;
    localparam int TO = 15;

    localparam int S_REG = 0, S_HI = 1, S_LO = 2, S_ZHI = 3, S_ZLO = 4,
                   S_PC = 5, S_MDR = 6, S_IN = 7, S_C = 8;
    localparam int WR_REG = 0, WR_HI = 1, WR_LO = 2, WR_Z = 3, WR_PC = 4,
                   WR_MDR = 5, WR_IR = 6, WR_Y = 7, WR_MAR = 8;

    logic             clk = 1'b0;
    logic             in_clr;
    logic [3:0]       in_regfile_location;
    logic [8:0]       in_bus_select;
    logic [8:0]       in_write;
    logic             in_inc_pc;
    logic [W-1:0]     in_inport_data, in_c_data;
    logic [2*W-1:0]   in_alu_result;
    logic [W-1:0]     out_alu_a, out_alu_b;
    logic             in_mem_start, in_mem_we;
    logic             out_mem_req, out_mem_we;
    logic [W-1:0]     out_mem_addr, out_mem_wdata;
    logic [W-1:0]     in_mem_rdata;
    logic             in_mem_ack;
    logic             out_mem_busy, out_mem_timeout, out_bus_error;
    logic [W-1:0]     out_bus, out_ir;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [63:0] value;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    datapath_gen #(.WIDTH(W), .NREGS(NR), .PC_STEP(1), .MEM_TIMEOUT(TO)) dut (
        .clk                 (clk),
        .in_clr              (in_clr),
        .in_regfile_location (in_regfile_location),
        .in_bus_select       (in_bus_select),
        .in_write            (in_write),
        .in_inc_pc           (in_inc_pc),
        .in_inport_data      (in_inport_data),
        .in_c_data           (in_c_data),
        .in_alu_result       (in_alu_result),
        .out_alu_a           (out_alu_a),
        .out_alu_b           (out_alu_b),
        .in_mem_start        (in_mem_start),
        .in_mem_we           (in_mem_we),
        .out_mem_req         (out_mem_req),
        .out_mem_we          (out_mem_we),
        .out_mem_addr        (out_mem_addr),
        .out_mem_wdata       (out_mem_wdata),
        .in_mem_rdata        (in_mem_rdata),
        .in_mem_ack          (in_mem_ack),
        .out_mem_busy        (out_mem_busy),
        .out_mem_timeout     (out_mem_timeout),
        .out_bus_error       (out_bus_error),
        .out_bus             (out_bus),
        .out_ir              (out_ir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] value);
        sb_entry_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [63:0] observed);
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, observed, e.value);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        in_clr        = 1'b0;
        in_bus_select = '0;
        in_write      = '0;
        in_inc_pc     = 1'b0;
        in_mem_start  = 1'b0;
        in_mem_we     = 1'b0;
        in_mem_ack    = 1'b0;
    endtask

    task automatic drive_c(input logic [W-1:0] value, input logic [8:0] wr);
        in_bus_select = 9'd1 << S_C;
        in_c_data     = value;
        in_write      = wr;
    endtask

    task automatic sel(input int src, input logic [3:0] loc);
        in_bus_select       = 9'd1 << src;
        in_regfile_location = loc;
    endtask

    initial begin
        quiet();
        in_regfile_location = '0;
        in_inport_data      = '0;
        in_c_data           = '0;
        in_alu_result       = '0;
        in_mem_rdata        = '0;

        // Reset: all state and flags zero
        in_clr = 1'b1;
        tick();
        in_clr = 1'b0;
        sb_push("rst_req", 0);      sb_check(64'(out_mem_req));
        sb_push("rst_busy", 0);     sb_check(64'(out_mem_busy));
        sb_push("rst_timeout", 0);  sb_check(64'(out_mem_timeout));
        sb_push("rst_bus_err", 0);  sb_check(64'(out_bus_error));
        sb_push("rst_bus", 0);      sb_check(64'(out_bus));
        sb_push("rst_addr", 0);     sb_check(64'(out_mem_addr));
        sb_push("rst_ir", 0);       sb_check(64'(out_ir));
        sel(S_PC, 0);
        #1;
        sb_push("rst_pc", 0);       sb_check(64'(out_bus));

        // Inport -> regfile[3], read back by index
        sel(S_IN, 4'd3);
        in_inport_data = 32'hA5A5_0001;
        in_write       = 9'd1 << WR_REG;
        tick();
        in_write = '0;
        sel(S_REG, 4'd3);
        #1;
        sb_push("reg3", 32'hA5A5_0001);  sb_check(64'(out_bus));
        sb_push("alu_b", 32'hA5A5_0001); sb_check(64'(out_alu_b));
        sel(S_REG, 4'd2);
        #1;
        sb_push("reg2", 0);              sb_check(64'(out_bus));

        // Z from ALU result, multi-register load of one bus value
        in_alu_result = 64'h1122_3344_5566_7788;
        drive_c(32'hCAFE_0000, (9'd1 << WR_Z) | (9'd1 << WR_HI) | (9'd1 << WR_LO)
                               | (9'd1 << WR_Y) | (9'd1 << WR_IR));
        tick();
        in_write = '0;
        sel(S_ZHI, 0); #1; sb_push("z_hi", 32'h1122_3344); sb_check(64'(out_bus));
        sel(S_ZLO, 0); #1; sb_push("z_lo", 32'h5566_7788); sb_check(64'(out_bus));
        sel(S_HI, 0);  #1; sb_push("hi", 32'hCAFE_0000);   sb_check(64'(out_bus));
        sel(S_LO, 0);  #1; sb_push("lo", 32'hCAFE_0000);   sb_check(64'(out_bus));
        sb_push("y", 32'hCAFE_0000);  sb_check(64'(out_alu_a));
        sb_push("ir", 32'hCAFE_0000); sb_check(64'(out_ir));

        // PC wrap and increment priority over write
        drive_c(32'hFFFF_FFFF, 9'd1 << WR_PC);
        tick();
        in_write = '0;
        sel(S_PC, 0); #1; sb_push("pc_load", 32'hFFFF_FFFF); sb_check(64'(out_bus));
        in_inc_pc = 1'b1;
        tick();
        in_inc_pc = 1'b0;
        #1; sb_push("pc_wrap", 0); sb_check(64'(out_bus));
        drive_c(32'h10, 9'd1 << WR_PC);
        in_inc_pc = 1'b1;
        tick();
        in_inc_pc = 1'b0;
        in_write  = '0;
        sel(S_PC, 0); #1; sb_push("pc_inc_prio", 1); sb_check(64'(out_bus));

        // Multi-select: bus 0, write suppressed, sticky error
        in_bus_select = (9'd1 << S_REG) | (9'd1 << S_MDR);
        in_regfile_location = 4'd3;
        in_write = 9'd1 << WR_Y;
        #1; sb_push("multi_bus", 0); sb_check(64'(out_bus));
        tick();
        quiet();
        sb_push("multi_y_kept", 32'hCAFE_0000); sb_check(64'(out_alu_a));
        sb_push("bus_err_set", 1);              sb_check(64'(out_bus_error));
        tick();
        sb_push("bus_err_sticky", 1);           sb_check(64'(out_bus_error));

        // Read with ack after 3 wait cycles; MAR write during wait ignored
        drive_c(32'h40, 9'd1 << WR_MAR);
        tick();
        quiet();
        sb_push("mar", 32'h40); sb_check(64'(out_mem_addr));
        in_mem_start = 1'b1;
        in_mem_we    = 1'b0;
        tick();
        quiet();
        sb_push("rd_req", 1);   sb_check(64'(out_mem_req));
        sb_push("rd_dir", 0);   sb_check(64'(out_mem_we));
        drive_c(32'h99, 9'd1 << WR_MAR);
        tick();
        quiet();
        tick();
        tick();
        sb_push("rd_still_busy", 1); sb_check(64'(out_mem_busy));
        in_mem_rdata = 32'hDEAD_BEEF;
        in_mem_ack   = 1'b1;
        tick();
        quiet();
        sb_push("rd_mdr", 32'hDEAD_BEEF); sb_check(64'(out_mem_wdata));
        sb_push("rd_done", 0);            sb_check(64'(out_mem_busy));
        sb_push("mar_kept", 32'h40);      sb_check(64'(out_mem_addr));

        // Write transaction: MDR frozen, restart ignored while busy
        drive_c(32'h1234_5678, 9'd1 << WR_MDR);
        tick();
        quiet();
        in_mem_start = 1'b1;
        in_mem_we    = 1'b1;
        tick();
        quiet();
        sb_push("wr_dir", 1); sb_check(64'(out_mem_we));
        drive_c(32'h0000_FFFF, 9'd1 << WR_MDR);
        in_mem_start = 1'b1;
        in_mem_we    = 1'b0;
        tick();
        quiet();
        sb_push("wr_restart_ign", 1); sb_check(64'(out_mem_we));
        in_mem_ack = 1'b1;
        tick();
        quiet();
        sb_push("wr_mdr_kept", 32'h1234_5678); sb_check(64'(out_mem_wdata));
        sb_push("wr_done", 0);                 sb_check(64'(out_mem_busy));

        // Read: memory capture beats simultaneous bus write to MDR
        in_mem_start = 1'b1;
        tick();
        quiet();
        in_mem_rdata = 32'h0BAD_F00D;
        in_mem_ack   = 1'b1;
        drive_c(32'h5555_5555, 9'd1 << WR_MDR);
        tick();
        quiet();
        sb_push("rd_prio", 32'h0BAD_F00D); sb_check(64'(out_mem_wdata));

        // Timeout: busy for exactly TO wait cycles, late ack ignored
        in_mem_start = 1'b1;
        tick();
        quiet();
        for (int i = 1; i < TO; i++) tick();
        sb_push("to_last_wait", 1);  sb_check(64'(out_mem_busy));
        sb_push("to_not_yet", 0);    sb_check(64'(out_mem_timeout));
        tick();
        sb_push("to_idle", 0);       sb_check(64'(out_mem_busy));
        sb_push("to_flag", 1);       sb_check(64'(out_mem_timeout));
        in_mem_rdata = 32'h1111_2222;
        in_mem_ack   = 1'b1;
        tick();
        quiet();
        sb_push("to_mdr_kept", 32'h0BAD_F00D); sb_check(64'(out_mem_wdata));
        sb_push("to_sticky", 1);               sb_check(64'(out_mem_timeout));

        // Reset mid-transaction aborts it
        in_mem_start = 1'b1;
        tick();
        quiet();
        sb_push("abort_busy", 1); sb_check(64'(out_mem_busy));
        in_clr = 1'b1;
        tick();
        quiet();
        sb_push("abort_req", 0);     sb_check(64'(out_mem_req));
        sb_push("abort_busy0", 0);   sb_check(64'(out_mem_busy));
        sb_push("abort_to", 0);      sb_check(64'(out_mem_timeout));
        sb_push("abort_berr", 0);    sb_check(64'(out_bus_error));
        sb_push("abort_dir", 0);     sb_check(64'(out_mem_we));
        sb_push("abort_addr", 0);    sb_check(64'(out_mem_addr));
        sb_push("abort_y", 0);       sb_check(64'(out_alu_a));
        in_mem_rdata = 32'h0000_0077;
        in_mem_ack   = 1'b1;
        tick();
        quiet();
        sb_push("abort_mdr", 0);     sb_check(64'(out_mem_wdata));
        sel(S_REG, 4'd3); #1; sb_push("abort_reg3", 0); sb_check(64'(out_bus));
        sel(S_PC, 0);     #1; sb_push("abort_pc", 0);   sb_check(64'(out_bus));

        if (sb_q.size() != 0) check("scoreboard_leftover", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/datapath_gen.md
DATAPATH_GEN -- requirements
Module: datapath_gen

Interface
REQ-001 Parameter WIDTH, default 32, data/bus/register width in bits (≥8).
REQ-002 Parameter NREGS, default 16, general-register count, power of two (≥2).
REQ-003 Parameter PC_STEP, default 1, PC increment amount.
REQ-004 Parameter MEM_TIMEOUT, default 15, maximum memory-wait cycles before abort (≥1).
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port in_clr, input, 1: reset, synchronous, active-high.
REQ-007 Port in_regfile_location, input, log2(NREGS): general-register index for both read and write.
REQ-008 Port in_bus_select, input, 9: one-hot bus source; bits 0..8 select, in order: regfile, HI, LO, Z-hi, Z-lo, PC, MDR, inport, C.
REQ-009 Port in_write, input, 9: write enables; bits 0..8 are, in order: regfile, HI, LO, Z, PC, MDR, IR, Y, MAR.
REQ-010 Port in_inc_pc, input, 1: increment PC this cycle.
REQ-011 Ports in_inport_data and in_c_data, input, WIDTH each: inport value and pre-extended constant.
REQ-012 Port in_alu_result, input, 2*WIDTH: external ALU result, loaded into Z.
REQ-013 Ports out_alu_a (Y) and out_alu_b (bus), output, WIDTH each: external ALU operands.
REQ-014 Ports in_mem_start and in_mem_we, input, 1 each: start memory transaction; in_mem_we=1 write, 0 read.
REQ-015 Ports out_mem_req and out_mem_we, output, 1 each: memory request and its direction (direction latched at start).
REQ-016 Ports out_mem_addr (MAR) and out_mem_wdata (MDR), output, WIDTH each.
REQ-017 Ports in_mem_rdata (WIDTH) and in_mem_ack (1), input: read data and completion.
REQ-018 Ports out_mem_busy, out_mem_timeout, out_bus_error, output, 1 each.
REQ-019 Ports out_bus and out_ir, output, WIDTH each: bus value and IR contents.

Function
REQ-020 Bus: exactly one select bit set → corresponding source; Z-hi = Z[2W-1:W], Z-lo = Z[W-1:0].
REQ-021 Bus, zero select bits → 0; no error.
REQ-022 Bus, more than one select bit set → 0, out_bus_error set (sticky until reset), and all in_write enables suppressed for that cycle.
REQ-023 Any number of write enables may be active together; every enabled register loads the bus, except Z, which loads in_alu_result.
REQ-024 PC: in_inc_pc=1 → PC ← (PC + PC_STEP) mod 2^WIDTH, taking priority over the PC write enable; otherwise the PC write enable loads the bus.
REQ-025 Memory FSM has two states, IDLE and WAIT; out_mem_busy = out_mem_req = (state==WAIT), both registered.
REQ-026 IDLE: in_mem_start=1 → WAIT next cycle, latch in_mem_we, clear wait counter.
REQ-027 WAIT, in_mem_ack=1 → IDLE next cycle; for a read, MDR ← in_mem_rdata on that same edge.
REQ-028 WAIT, no ack → counter+1; counter reaching MEM_TIMEOUT → IDLE, out_mem_timeout set (sticky until reset), MDR unchanged.
REQ-029 Latency: start at edge n → req high after n; ack sampled at edge n+1 → MDR valid and busy low after n+1.
REQ-030 in_mem_start is ignored while busy.
REQ-031 While busy, MAR writes are ignored; MDR bus writes are ignored during a write transaction.
REQ-032 During a read, a memory capture on the ack edge takes priority over a simultaneous MDR bus write.
REQ-033 in_mem_ack while IDLE is ignored.

Reset
REQ-034 On in_clr at a clock edge, the following are zeroed: all general registers, PC, IR, Y, Z, MAR, MDR, HI, LO, the counter, and all sticky flags; the FSM returns to IDLE.
REQ-035 After reset, out_mem_req, out_mem_busy, out_mem_timeout and out_bus_error are 0, and out_bus follows the bus select (0 with no select).
REQ-036 Reset mid-transaction aborts it: a later ack is ignored and MDR is not loaded.

Verification
REQ-037 Select inport = 0xA5A5_0001, write regfile[3]; then select regfile at index 3 → out_bus = 0xA5A5_0001.
REQ-038 PC = 0xFFFF_FFFF, in_inc_pc → PC = 0; in_inc_pc together with PC write of 0x10 → PC = 1.
REQ-039 Select regfile and MDR together with Y write → out_bus = 0, Y unchanged, out_bus_error = 1 until in_clr.
REQ-040 MAR = 0x40; read start; ack after 3 wait cycles with rdata 0xDEAD_BEEF → MDR = 0xDEAD_BEEF and busy low the next cycle; a MAR write during the wait is ignored.
REQ-041 Read start with no ack → IDLE after MEM_TIMEOUT wait cycles, out_mem_timeout = 1, MDR unchanged; a late ack has no effect.
REQ-042 in_clr asserted while in WAIT → IDLE with all outputs 0; an ack in the next cycle leaves MDR = 0.
